fifo_word_assembler: RTL and testbench
======================================

// Module: fifo_word_assembler
// PURPOSE
//   Read end of the FIFO/SRFIFO entry interface. Pops BITS-wide entries from the FIFO head
//   and packs COUNT consecutive entries into one word, e.g. instruction bytes into an opcode word.
//   Presents each word on a valid/ready port to the decode stage.
//   Flush discards partial and held words, e.g. on a jump.
// PARAMETERS
//   BITS   8  width of one FIFO entry
//   COUNT  2  entries per output word (>=1); count reg width CW = $clog2(COUNT+1)
// PORTS
//   clk         in   1           clock, all state updates on posedge
//   reset_n     in   1           synchronous reset, active-low
//   fifo_valid  in   1           FIFO head entry valid (connects to last_valid / !empty)
//   fifo_entry  in   BITS        FIFO head entry (connects to last_entry)
//   fifo_remove out  1           pop FIFO head this cycle (connects to FIFO remove)
//   flush       in   1           discard all collected/held data
//   out_valid   out  1           out_word holds a complete word
//   out_ready   in   1           consumer accepts out_word this cycle
//   out_word    out  BITS*COUNT  assembled word; first popped entry in bits [BITS-1:0]
// BEHAVIOUR
//   - One clock, synchronous active-low reset. reset_n=0 -> count=0, out_valid=0, out_word=0.
//     fifo_remove=0 while reset_n=0, whatever fifo_valid is.
//   - State: count (0..COUNT) of entries held. out_valid = (count==COUNT), driven from a register.
//   - accept = out_valid && out_ready.
//   - fifo_remove = reset_n && fifo_valid && !flush && (!out_valid || out_ready). It is combinational.
//     It is never high without fifo_valid, so an SRFIFO is never popped while empty.
//   - Pop: fifo_entry is written to slot[k] of out_word, with k = accept ? 0 : count.
//   - Next count:
//       flush                        -> 0
//       else accept &&  fifo_remove  -> 1
//       else accept && !fifo_remove  -> 0
//       else fifo_remove             -> count+1
//       else                         -> count
//   - Latency: the COUNTth pop in cycle t gives out_valid=1 in cycle t+1. No combinational path
//     from fifo_entry to out_word.
//   - Throughput: one word per COUNT cycles with a continuous FIFO and out_ready held high.
//     The pop in the accept cycle overlaps, so the accept cycle costs no bubble.
//   - Backpressure: while out_valid && !out_ready, out_word and out_valid hold and fifo_remove=0.
//   - Slots above count-1 keep stale data. Consumers use out_word only when out_valid=1.
//   - flush: has priority over everything. No pop in a flush cycle. count=0 and out_valid=0 next cycle.
//     A word offered in the flush cycle with out_ready=1 counts as consumed by the consumer;
//     the block keeps no trace of it either way.
//   - COUNT=1: degenerates to a one-entry registered pipeline stage with the same rules.
//   - Reset mid-word: partial data dropped, no pop in the reset cycle. FIFO reset is separate.
// TESTING
//   1 reset_n=0 with fifo_valid=1 for 2 cycles -> fifo_remove=0, out_valid=0, out_word=0; count=0 after release
//   2 BITS=8,COUNT=2, FIFO gives 0x34,0x12 back-to-back, out_ready=1 -> out_word=0x1234 one cycle after the 2nd pop
//   3 Stream 0x11..0x16, out_ready=1 -> words 0x2211,0x4433,0x6655 on consecutive 2-cycle boundaries, no bubble
//   4 Word 0xBBAA valid, out_ready=0 for 3 cycles, FIFO non-empty -> fifo_remove=0, out_word stable 0xBBAA; ready=1 -> pops 0xCC same cycle
//   5 count=1 (0x77 held), flush=1 with fifo_valid=1 -> no pop; then 0x01,0x02 -> out_word=0x0201 (0x77 lost)
//   6 fifo_valid toggling 1,0,1 (gaps) -> remove only in valid cycles, word formed after 2nd valid pop

Source files
------------

// File: rtl/fifo_word_assembler_if.sv
// fifo_word_assembler_if: FIFO-head pop port and assembled-word valid/ready port.
interface fifo_word_assembler_if #(
    parameter int BITS  = 8,
    parameter int COUNT = 2
);
    logic                  fifo_valid;
    logic [BITS-1:0]       fifo_entry;
    logic                  fifo_remove;
    logic                  out_valid;
    logic                  out_ready;
    logic [BITS*COUNT-1:0] out_word;
    modport master (
        input  fifo_valid, fifo_entry, out_ready,
        output fifo_remove, out_valid, out_word
    );
    modport slave (
        output fifo_valid, fifo_entry, out_ready,
        input  fifo_remove, out_valid, out_word
    );
endinterface

// File: rtl/fifo_word_assembler.sv
// fifo_word_assembler: pops COUNT FIFO entries and presents them as one registered word.
module fifo_word_assembler #(
    parameter int BITS  = 8,
    parameter int COUNT = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    fifo_word_assembler_if.master  bus
);
    localparam int CW = $clog2(COUNT + 1);
    logic [CW-1:0]         count, count_nxt, k;
    logic                  valid, accept, remove;
    logic [BITS*COUNT-1:0] word, word_nxt;
    // An accepted word frees every slot, so a pop in that cycle restarts at slot 0.
    always_comb begin
        accept    = valid && bus.out_ready;
        remove    = reset_n && bus.fifo_valid && !flush && (!valid || bus.out_ready);
        k         = accept ? '0 : count;
        count_nxt = flush ? '0 : accept ? CW'(remove) : remove ? count + CW'(1) : count;
        word_nxt  = word;
        for (int i = 0; i < COUNT; i++)
            if (remove && k == CW'(i)) word_nxt[i*BITS +: BITS] = bus.fifo_entry;
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
            valid <= 1'b0;
            word  <= '0;
        end else begin
            count <= count_nxt;
            valid <= count_nxt == CW'(COUNT);
            word  <= word_nxt;
        end
    end
    assign bus.fifo_remove = remove;
    assign bus.out_valid   = valid;
    assign bus.out_word    = word;
endmodule

// File: tb/tb_fifo_word_assembler.sv
// tb_fifo_word_assembler: directed vector table plus randomized run against a queue model.
module tb_fifo_word_assembler;
    localparam int BITS  = 8;
    localparam int COUNT = 2;
    logic clk = 1'b0;
    logic reset_n, flush;
    int passed = 0, total = 0;
    fifo_word_assembler_if #(.BITS(BITS), .COUNT(COUNT)) bus ();
    fifo_word_assembler #(.BITS(BITS), .COUNT(COUNT)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bus)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        rst_n, fl, fv;
        logic [7:0]  e;
        logic        rdy, x_rem, x_val, chk_w;
        logic [15:0] x_word;
    } vec_t;
    vec_t vecs[$];
    logic [BITS-1:0] held[$];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    // Drive one cycle's inputs and stop at the falling edge for sampling.
    task automatic drive(input logic r, input logic f, input logic v, input logic [7:0] e, input logic rd);
        reset_n = r; flush = f; bus.fifo_valid = v; bus.fifo_entry = e; bus.out_ready = rd;
        @(negedge clk);
    endtask
    task automatic add(input logic r, f, v, input logic [7:0] e, input logic rd, xr, xv, cw, input logic [15:0] xw);
        vec_t t;
        t.rst_n = r; t.fl = f; t.fv = v; t.e = e; t.rdy = rd;
        t.x_rem = xr; t.x_val = xv; t.chk_w = cw; t.x_word = xw;
        vecs.push_back(t);
    endtask
    initial begin
        logic [15:0] xw;
        logic xv, xr, r, f, v, rd;
        logic [7:0] e;
        // reset held with FIFO valid
        add(0,0,1,8'h55,1, 0,0,1,16'h0000);
        add(0,0,1,8'h56,1, 0,0,1,16'h0000);
        // two pops form 0x1234
        add(1,0,1,8'h34,1, 1,0,1,16'h0000);
        add(1,0,1,8'h12,1, 1,0,0,16'h0000);
        add(1,0,0,8'h00,1, 0,1,1,16'h1234);
        // continuous stream, no bubble
        add(1,0,1,8'h11,1, 1,0,0,16'h0000);
        add(1,0,1,8'h22,1, 1,0,0,16'h0000);
        add(1,0,1,8'h33,1, 1,1,1,16'h2211);
        add(1,0,1,8'h44,1, 1,0,0,16'h0000);
        add(1,0,1,8'h55,1, 1,1,1,16'h4433);
        add(1,0,1,8'h66,1, 1,0,0,16'h0000);
        // backpressure on 0xBBAA
        add(1,0,1,8'hAA,1, 1,1,1,16'h6655);
        add(1,0,1,8'hBB,0, 1,0,0,16'h0000);
        add(1,0,1,8'hCC,0, 0,1,1,16'hBBAA);
        add(1,0,1,8'hCC,0, 0,1,1,16'hBBAA);
        add(1,0,1,8'hCC,0, 0,1,1,16'hBBAA);
        add(1,0,1,8'hCC,1, 1,1,1,16'hBBAA);
        // 0x77 held, then flushed
        add(1,0,1,8'hDD,1, 1,0,0,16'h0000);
        add(1,0,1,8'h77,1, 1,1,1,16'hDDCC);
        add(1,1,1,8'h99,1, 0,0,0,16'h0000);
        add(1,0,1,8'h01,1, 1,0,0,16'h0000);
        add(1,0,1,8'h02,1, 1,0,0,16'h0000);
        add(1,0,0,8'h00,0, 0,1,1,16'h0201);
        // flush while a word is offered
        add(1,1,1,8'hEE,1, 0,1,1,16'h0201);
        add(1,0,0,8'h00,1, 0,0,0,16'h0000);
        // gaps in fifo_valid
        add(1,0,1,8'hA1,1, 1,0,0,16'h0000);
        add(1,0,0,8'hA2,1, 0,0,0,16'h0000);
        add(1,0,1,8'hB2,1, 1,0,0,16'h0000);
        add(1,0,0,8'h00,1, 0,1,1,16'hB2A1);
        // reset mid-word
        add(1,0,1,8'hC1,1, 1,0,0,16'h0000);
        add(0,0,1,8'hC2,1, 0,0,0,16'h0000);
        add(1,0,0,8'h00,1, 0,0,1,16'h0000);
        add(1,0,1,8'hD1,0, 1,0,0,16'h0000);
        add(1,0,1,8'hD2,0, 1,0,0,16'h0000);
        add(1,0,1,8'hD3,0, 0,1,1,16'hD2D1);
        drive(0, 0, 1, 8'h00, 0);
        @(posedge clk); #1;
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].fl, vecs[i].fv, vecs[i].e, vecs[i].rdy);
            check($sformatf("vec%0d remove", i), 32'(bus.fifo_remove), 32'(vecs[i].x_rem));
            check($sformatf("vec%0d valid", i), 32'(bus.out_valid), 32'(vecs[i].x_val));
            if (vecs[i].chk_w) check($sformatf("vec%0d word", i), 32'(bus.out_word), 32'(vecs[i].x_word));
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 8'h00, 0);
        @(posedge clk); #1;
        held.delete();
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom_range(0, 99) >= 2;
            f  = $urandom_range(0, 99) < 4;
            v  = $urandom_range(0, 99) < 70;
            rd = $urandom_range(0, 99) < 60;
            e  = 8'($urandom);
            drive(r, f, v, e, rd);
            xv = held.size() == COUNT;
            xr = r && v && !f && (!xv || rd);
            xw = '0;
            foreach (held[j]) xw[j*BITS +: BITS] = held[j];
            check("rand remove", 32'(bus.fifo_remove), 32'(xr));
            check("rand valid", 32'(bus.out_valid), 32'(xv));
            if (xv) check("rand word", 32'(bus.out_word), 32'(xw));
            if (!r || f) held.delete();
            else begin
                if (xv && rd) held.delete();
                if (xr) held.push_back(e);
            end
            @(posedge clk); #1;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
